// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: two-entry skid buffer carrying a data bundle and PC with valid/ready handshake.
// Optional stall/flush statistics counters are built only when PIPE_STAT_EN is defined.
module pipe_stage_reg #(
    parameter int          DATA_W = 160,
    parameter logic [31:0] PC_RST = 32'h0000_3000,
    parameter int          CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_pc,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [31:0]       r_main_pc;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [31:0]       r_skid_pc;
    logic              r_in_ready;

    logic              w_accept;
    logic              w_drain;
    logic              w_main_valid_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [31:0]       w_main_pc_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic [31:0]       w_skid_pc_nxt;

    // Handshake qualifiers; in_ready comes from a register so out_ready never reaches it combinationally.
    always_comb begin
        w_accept = in_valid && r_in_ready && !flush;
        w_drain  = r_main_valid && out_ready;
    end

    // Slot next-state: flush empties both slots, otherwise skid refills main first.
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_main_pc_nxt    = r_main_pc;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        w_skid_pc_nxt    = r_skid_pc;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_main_data_nxt  = '0;
            w_main_pc_nxt    = PC_RST;
            w_skid_valid_nxt = 1'b0;
            w_skid_data_nxt  = '0;
            w_skid_pc_nxt    = PC_RST;
        end else if (w_drain && r_skid_valid) begin
            w_main_valid_nxt = 1'b1;
            w_main_data_nxt  = r_skid_data;
            w_main_pc_nxt    = r_skid_pc;
            w_skid_valid_nxt = 1'b0;
        end else if (w_drain) begin
            if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = in_data;
                w_main_pc_nxt    = in_pc;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (!r_main_valid) begin
            if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = in_data;
                w_main_pc_nxt    = in_pc;
            end else begin
                w_main_valid_nxt = r_main_valid;
            end
        end else if (w_accept) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = in_data;
            w_skid_pc_nxt    = in_pc;
        end else begin
            w_skid_valid_nxt = r_skid_valid;
        end
    end

    // Slot and in_ready registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_pc    <= PC_RST;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_pc    <= PC_RST;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_main_pc    <= w_main_pc_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_pc    = r_main_pc;
    assign in_ready  = r_in_ready;

`ifdef PIPE_STAT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == {CNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + CNT_W'(1);
        end
        return res;
    endfunction

    // Saturating hazard counters, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_main_valid && !out_ready) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (flush) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, stall/skid, flush, counter saturation, async reset.
module tb_pipe_stage_reg;

    localparam int          DATA_W = 160;
    localparam logic [31:0] PC_RST = 32'h0000_3000;
    localparam int          CNT_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [31:0]       in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [31:0]       out_pc;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .PC_RST(PC_RST), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pc    (out_pc),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk_data(input logic [31:0] pc);
        return {pc, ~pc, pc ^ 32'hA5A5_5A5A, pc + 32'd1, 32'hC0DE_0000 | pc};
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_data  = mk_data(pc);
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] pc);
        chk({tag, "_v"}, DATA_W'(out_valid), DATA_W'(1'b1));
        chk({tag, "_pc"}, DATA_W'(out_pc), DATA_W'(pc));
        chk({tag, "_d"}, out_data, mk_data(pc));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_v"}, DATA_W'(out_valid), DATA_W'(1'b0));
        chk({tag, "_rdy"}, DATA_W'(in_ready), DATA_W'(1'b1));
        chk({tag, "_pc"}, DATA_W'(out_pc), DATA_W'(PC_RST));
        chk({tag, "_d"}, out_data, '0);
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] st, input logic [CNT_W-1:0] fl);
`ifdef PIPE_STAT_EN
        chk({tag, "_stall"}, DATA_W'(stall_cnt), DATA_W'(st));
        chk({tag, "_flush"}, DATA_W'(flush_cnt), DATA_W'(fl));
`else
        chk({tag, "_stall"}, DATA_W'(stall_cnt), DATA_W'(0));
        chk({tag, "_flush"}, DATA_W'(flush_cnt), DATA_W'(0));
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 32'd0;
        in_data   = '0;
        out_ready = 1'b1;
        do_reset();
        tick();
        chk_empty("idle");
        chk_cnt("idle", 3'd0, 3'd0);

        // Back-to-back stream, one beat per cycle.
        for (int i = 0; i < 8; i++) begin
            offer(32'h0000_3000 + 32'(4 * i));
            tick();
            chk_beat($sformatf("strm%0d", i), 32'h0000_3000 + 32'(4 * i));
            chk($sformatf("strm%0d_rdy", i), DATA_W'(in_ready), DATA_W'(1'b1));
        end
        in_valid = 1'b0;
        tick();
        chk("strm_end_v", DATA_W'(out_valid), DATA_W'(1'b0));

        // Three-cycle stall while beat 2 is in main.
        offer(32'h0000_3100); tick(); chk_beat("st_b0", 32'h0000_3100);
        offer(32'h0000_3104); tick(); chk_beat("st_b1", 32'h0000_3104);
        offer(32'h0000_3108); tick(); chk_beat("st_b2", 32'h0000_3108);
        out_ready = 1'b0;
        offer(32'h0000_310C); tick();
        chk_beat("st_e4", 32'h0000_3108);
        chk("st_e4_rdy", DATA_W'(in_ready), DATA_W'(1'b0));
        offer(32'h0000_3110); tick();
        chk_beat("st_e5", 32'h0000_3108);
        chk("st_e5_rdy", DATA_W'(in_ready), DATA_W'(1'b0));
        tick();
        chk_beat("st_e6", 32'h0000_3108);
        chk("st_e6_rdy", DATA_W'(in_ready), DATA_W'(1'b0));
        out_ready = 1'b1;
        tick();
        chk_beat("st_b3", 32'h0000_310C);
        chk("st_b3_rdy", DATA_W'(in_ready), DATA_W'(1'b1));
        tick();
        chk_beat("st_b4", 32'h0000_3110);
        in_valid = 1'b0;
        tick();
        chk("st_end_v", DATA_W'(out_valid), DATA_W'(1'b0));
        chk_cnt("st", 3'd3, 3'd0);

        // Flush with skid full and a beat on the input.
        out_ready = 1'b0;
        offer(32'h0000_3200); tick(); chk_beat("fl_m", 32'h0000_3200);
        offer(32'h0000_3204); tick();
        chk("fl_skid_rdy", DATA_W'(in_ready), DATA_W'(1'b0));
        flush = 1'b1;
        offer(32'h0000_3208); tick();
        chk_empty("fl");
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl_post1_v", DATA_W'(out_valid), DATA_W'(1'b0));
        tick();
        chk("fl_post2_v", DATA_W'(out_valid), DATA_W'(1'b0));
        chk_cnt("fl", 3'd5, 3'd1);

        // Stall counter saturates at all-ones.
        do_reset();
        out_ready = 1'b0;
        offer(32'h0000_3300); tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk_beat("sat_hold", 32'h0000_3300);
        chk_cnt("sat", 3'd7, 3'd0);

        // Asynchronous reset between edges mid-stream.
        out_ready = 1'b1;
        offer(32'h0000_3400); tick();
        offer(32'h0000_3404); tick();
        chk_beat("ar_pre", 32'h0000_3404);
        #2 reset = 1'b1;
        #1;
        chk_empty("ar");
        chk_cnt("ar", 3'd0, 3'd0);
        #1 reset = 1'b0;
        offer(32'h0000_3500); tick(); chk_beat("ar_r0", 32'h0000_3500);
        offer(32'h0000_3504); tick(); chk_beat("ar_r1", 32'h0000_3504);
        in_valid = 1'b0;
        tick();
        chk("ar_end_v", DATA_W'(out_valid), DATA_W'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline stage register for the P6 five-stage pipeline, replacing the fixed per-stage D/E, E/M and M/W registers. It carries an opaque control/data bundle plus the stage PC through a two-entry skid buffer with valid/ready handshaking, so a stage can stall without a combinational ready path to its upstream stage. Flush inserts a bubble whose PC matches the reset vector, as the existing stage registers do. Optional hazard counters report stall and flush activity.

## Interface
- DATA_W, 160, width of the opaque bundle (control fields, operands, instr, rs/rt, Tnew)
- PC_RST, 32'h00003000, PC value held by an empty slot after reset and after flush
- CNT_W, 16, width of each statistics counter
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  synchronous bubble insertion (branch/exception kill)
- in_valid  in  1  upstream offers a beat
- in_ready  out  1  stage can take a beat; equals !skid_valid (registered)
- in_data  in  DATA_W  upstream bundle
- in_pc  in  32  upstream PC
- out_valid  out  1  main slot holds a live beat
- out_ready  in  1  downstream takes the beat this cycle
- out_data  out  DATA_W  main slot bundle
- out_pc  out  32  main slot PC
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready
- flush_cnt  out  CNT_W  cycles with flush asserted

## Operation
- Storage: main slot {main_valid, main_data, main_pc}, skid slot {skid_valid, skid_data, skid_pc}. out_* drive main slot directly.
- accept = in_valid && in_ready && !flush; drain = out_valid && out_ready.
- Per cycle, flush = 0:
  - drain && skid_valid: main <- skid; skid empty; if accept, skid <- input (cannot occur: in_ready = 0 when skid_valid).
  - drain && !skid_valid: main <- input if accept, else main_valid <- 0.
  - !drain && !main_valid: main <- input if accept.
  - !drain && main_valid && accept: skid <- input; main unchanged.
  - otherwise hold.
- flush = 1 (priority over everything except reset): main_valid, skid_valid <- 0; both data <- 0; both pc <- PC_RST; input beat in same cycle dropped; a drain in that cycle still counts for downstream.
- Empty-slot contents: data 0, pc PC_RST; out_data/out_pc show these whenever out_valid = 0 after reset or flush. After a plain drain the main slot data is don't-care-but-stable (holds last beat).
- Ordering: beats leave in acceptance order; no beat duplicated or lost except by flush.
- Counters: increment by 1 on their condition, saturate at all-ones, cleared only by reset.

## Timing
- Reset (asynchronous assert): out_valid 0, in_ready 1, out_data 0, out_pc PC_RST, skid empty, stall_cnt 0, flush_cnt 0. Deassertion must be synchronous to clk externally.
- Latency: beat accepted at edge N appears on out_* after edge N (visible cycle N+1) when main slot empty or draining.
- Throughput: one beat per cycle with out_ready held 1.
- in_ready depends only on registers; no combinational path from out_ready to in_ready.
- Stall: first cycle out_ready = 0 with a live beat, one further beat lands in skid; in_ready drops next cycle. On out_ready returning, skid moves to main and in_ready rises the following cycle.
- Reset mid-operation: all beats discarded at once, counters zeroed.

## Configuration
- PIPE_STAT_EN defined: stall_cnt and flush_cnt implemented as above.
- Undefined: counter registers omitted; stall_cnt and flush_cnt tied to 0; datapath behaviour unchanged.

## Test plan
- Reset then idle: out_valid 0, in_ready 1, out_pc 32'h00003000, out_data 0, counters 0.
- Stream 8 beats pc 0x3000..0x301C, out_ready = 1: each appears one cycle after accept, in order, no gaps.
- Stream with out_ready = 0 for 3 cycles at beat 2: beat 3 captured in skid, in_ready 0 for remaining stall cycles, then beats 2,3,4 emerge in order; stall_cnt = 3 (PIPE_STAT_EN).
- flush while skid full and in_valid = 1: next cycle out_valid 0, in_ready 1, out_pc 32'h00003000, out_data 0; flushed and simultaneous input beats never appear; flush_cnt = 1.
- Async reset pulsed mid-stream between clock edges: outputs reach reset values before next posedge; stream restarts cleanly.
- Build without PIPE_STAT_EN, repeat stall test: identical out_* sequence, stall_cnt and flush_cnt constant 0.
